chan_step_loader: RTL
=====================

# chan_step_loader

Synthesizable sequencer that loads the emulated channel's step-response table. Host or bench streams NUMEL+1 fixed-point step samples over a valid/ready port. The block writes NUMEL table entries (value, slope) on the channel write port (chan_wdata_0, chan_wdata_1, chan_waddr, chan_we) into the downstream channel model memory, replacing the bench-driven loop. Slope entry i is s[i+1]-s[i], computed in hardware with one-sample lookahead.

## Interface
- FUNC_DATA_WIDTH, 18, width of each sample and table word (signed fixed-point, exponent -16)
- NUMEL, 512, number of table entries written per load
- ADDR_WIDTH, 9, width of chan_waddr; must satisfy 2**ADDR_WIDTH >= NUMEL
- emu_clk  input  1  sole clock
- emu_rst  input  1  synchronous, active-high reset
- start  input  1  begin a load; sampled only in IDLE or DONE
- in_data  input  FUNC_DATA_WIDTH  step sample s[k], signed
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- chan_wdata_0  output  FUNC_DATA_WIDTH  table value s[i]
- chan_wdata_1  output  FUNC_DATA_WIDTH  table slope s[i+1]-s[i]
- chan_waddr  output  ADDR_WIDTH  table address i
- chan_we  output  1  one-cycle write strobe
- busy  output  1  load in progress
- done  output  1  load complete, held
- slope_ovf  output  1  sticky slope-overflow flag

## Operation
- States: IDLE, PRIME, STREAM, DONE.
- IDLE: in_ready=0. start=1 -> PRIME; clear idx, slope_ovf.
- PRIME: in_ready=1. Accept (in_valid & in_ready) loads prev<=in_data -> STREAM. No write.
- STREAM: in_ready=1. Each accept of x: chan_wdata_0<=prev, chan_wdata_1<=slope(x,prev), chan_waddr<=idx, chan_we<=1; prev<=x; idx<=idx+1. Accept with idx==NUMEL-1 -> DONE.
- Cycle without accept: chan_we<=0; data/address outputs hold.
- DONE: done=1, in_ready=0. start=1 -> PRIME (restart, done cleared, idx/slope_ovf cleared).
- busy=1 in PRIME and STREAM.
- start is ignored in PRIME/STREAM.
- Exactly NUMEL+1 samples are accepted per load; addresses 0..NUMEL-1 written once each, in ascending order, with no gaps and no wrap.
- Slope arithmetic: difference formed at FUNC_DATA_WIDTH+1 bits, signed; result reduced to FUNC_DATA_WIDTH per Configuration.
- Fixed-point only; recoded-float table format is not supported by this block.

## Timing
- Reset values: in_ready=0, chan_wdata_0=0, chan_wdata_1=0, chan_waddr=0, chan_we=0, busy=0, done=0, slope_ovf=0; state=IDLE.
- in_ready is a combinational decode of state only; it does not depend on in_valid.
- Write latency: chan_we asserted the cycle after the accepting edge; sustained throughput one entry per cycle.
- Full load with in_valid held high: start at cycle 0, PRIME accept cycle 1, last write strobe at cycle NUMEL+2, done=1 from cycle NUMEL+2.
- done rises in the same cycle as the final chan_we.
- Reset mid-load: next cycle all outputs at reset values, no further writes; table contents already written are not invalidated.
- start coincident with emu_rst: reset wins.

## Configuration
- CHAN_SLOPE_SAT_EN defined: out-of-range slope saturates to max/min signed FUNC_DATA_WIDTH value and sets slope_ovf (sticky until next start or reset).
- Undefined: slope truncated to low FUNC_DATA_WIDTH bits (two's-complement wrap); slope_ovf tied 0.

## Structure
- Package chan_loader_pack: state enum typedef (IDLE, PRIME, STREAM, DONE), sample typedef of FUNC_DATA_WIDTH signed bits.
- Sub-module chan_slope_calc: combinational widened subtract plus saturation/overflow detect under CHAN_SLOPE_SAT_EN; the top holds FSM, prev register, counter, output registers.

## Test plan
- Ramp s[k]=k*16, NUMEL=512, in_valid always 1 -> 512 strobes, entry i = (16i, 16), last strobe at cycle 514, done=1, slope_ovf=0.
- Exponential step, 1.0-exp(-(t-31.25ps)/25ps) at 6.25ps spacing -> each entry matches bench-computed FLOAT_TO_FIXED(.,-16) value and difference exactly.
- in_valid toggled 1-0-1 pseudo-randomly -> no gaps or duplicate addresses, chan_we only after accepts, final table identical to the uninterrupted run.
- s[0]=+131071, s[1]=-131072, CHAN_SLOPE_SAT_EN defined -> entry 0 slope=-131072, slope_ovf=1; without the macro -> slope=+1, slope_ovf=0.
- emu_rst asserted after 100 writes -> next cycle chan_we=0, busy=0, state IDLE; new start reloads from address 0.
- start pulsed during STREAM and again in DONE -> first ignored, second restarts the load with done cleared.

Source files
------------

// File: rtl/chan_loader_pack.sv
// Shared types for the channel step-response table loader.
// Optional feature macro used by this slice: CHAN_SLOPE_SAT_EN.
package chan_loader_pack;

    localparam int CHAN_SAMPLE_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } state_t;

    typedef logic signed [CHAN_SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/chan_slope_calc.sv
// Slope s[i+1]-s[i] formed one bit wider than the samples, then reduced to sample width.
// CHAN_SLOPE_SAT_EN defined: saturate and flag overflow; otherwise two's-complement wrap.
module chan_slope_calc #(
    parameter int FUNC_DATA_WIDTH = 18
) (
    input  logic signed [FUNC_DATA_WIDTH-1:0] cur,
    input  logic signed [FUNC_DATA_WIDTH-1:0] prev,
    output logic signed [FUNC_DATA_WIDTH-1:0] slope,
    output logic                              ovf
);

`ifdef CHAN_SLOPE_SAT_EN
    logic signed [FUNC_DATA_WIDTH:0] diff;

    // The two top bits of the widened difference disagree exactly when it does not fit.
    always_comb begin
        diff = {cur[FUNC_DATA_WIDTH-1], cur} - {prev[FUNC_DATA_WIDTH-1], prev};
        ovf  = diff[FUNC_DATA_WIDTH] ^ diff[FUNC_DATA_WIDTH-1];
        if (!ovf) begin
            slope = diff[FUNC_DATA_WIDTH-1:0];
        end else if (diff[FUNC_DATA_WIDTH]) begin
            slope = {1'b1, {(FUNC_DATA_WIDTH-1){1'b0}}};
        end else begin
            slope = {1'b0, {(FUNC_DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    // Keeping only the low bits of the wide difference equals a native-width subtract.
    assign slope = cur - prev;
    assign ovf   = 1'b0;
`endif

endmodule

// File: rtl/chan_step_loader.sv
// Streams NUMEL+1 step samples in and writes NUMEL (value, slope) entries to the channel table.
// Slope overflow handling selected by CHAN_SLOPE_SAT_EN (see chan_slope_calc).
module chan_step_loader
    import chan_loader_pack::*;
#(
    parameter int FUNC_DATA_WIDTH = CHAN_SAMPLE_WIDTH,
    parameter int NUMEL           = 512,
    parameter int ADDR_WIDTH      = 9
) (
    input  logic                       emu_clk,
    input  logic                       emu_rst,
    input  logic                       start,
    input  logic [FUNC_DATA_WIDTH-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [FUNC_DATA_WIDTH-1:0] chan_wdata_0,
    output logic [FUNC_DATA_WIDTH-1:0] chan_wdata_1,
    output logic [ADDR_WIDTH-1:0]      chan_waddr,
    output logic                       chan_we,
    output logic                       busy,
    output logic                       done,
    output logic                       slope_ovf
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUMEL - 1);

    state_t                       state;
    state_t                       state_nxt;
    logic [ADDR_WIDTH-1:0]        idx;
    logic [FUNC_DATA_WIDTH-1:0]   prev;
    logic signed [FUNC_DATA_WIDTH-1:0] slope;
    logic                         slope_of;
    logic                         accept;
    logic                         start_ok;

    chan_slope_calc #(
        .FUNC_DATA_WIDTH(FUNC_DATA_WIDTH)
    ) u_slope (
        .cur  (in_data),
        .prev (prev),
        .slope(slope),
        .ovf  (slope_of)
    );

    // Handshake and status are pure state decodes so in_ready never depends on in_valid.
    always_comb begin
        in_ready  = (state == PRIME) || (state == STREAM);
        busy      = in_ready;
        done      = (state == DONE);
        accept    = in_valid && in_ready;
        start_ok  = start && ((state == IDLE) || (state == DONE));
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = PRIME;
            PRIME:  if (accept) state_nxt = STREAM;
            STREAM: if (accept && (idx == LAST_IDX)) state_nxt = DONE;
            DONE:   if (start) state_nxt = PRIME;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state        <= IDLE;
            idx          <= '0;
            prev         <= '0;
            chan_wdata_0 <= '0;
            chan_wdata_1 <= '0;
            chan_waddr   <= '0;
            chan_we      <= 1'b0;
            slope_ovf    <= 1'b0;
        end else begin
            state   <= state_nxt;
            chan_we <= 1'b0;
            if (start_ok) begin
                idx       <= '0;
                slope_ovf <= 1'b0;
            end
            if ((state == PRIME) && accept) begin
                prev <= in_data;
            end
            // Each STREAM accept commits the entry for the previously held sample.
            if ((state == STREAM) && accept) begin
                chan_wdata_0 <= prev;
                chan_wdata_1 <= slope;
                chan_waddr   <= idx;
                chan_we      <= 1'b1;
                prev         <= in_data;
                idx          <= idx + 1'b1;
                slope_ovf    <= slope_ovf | slope_of;
            end
        end
    end

endmodule
